// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core, filled from a byte-stream loader.
// The core is held in reset while a program is being loaded and is released
// once the declared number of words has been written.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  output logic                  ld_ready_o,
  output logic [DEPTH_LOG2:0]   ld_count_o,
  output logic                  ld_err_o,
  output logic                  core_rst_o
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  localparam logic [16:0] CAP   = 17'(WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [31:0] mem [0:WORDS-1];

  logic [7:0]          len_hi;
  logic [15:0]         len;
  logic [23:0]         word_sr;
  logic [1:0]          byte_idx;
  logic [DEPTH_LOG2:0] count;

  logic                accept;
  logic [15:0]         len_full;
  logic [DEPTH_LOG2:0] count_inc;
  logic                word_done;
  logic [31:0]         addr_hi;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign accept    = ld_valid_i & ld_ready_o;
  assign len_full  = {len_hi, ld_byte_i};
  assign count_inc = count + 1'b1;
  assign word_done = accept && (state == DATA) && (byte_idx == 2'd3);

  // Fetch path: combinational lookup, zero when disabled or out of range;
  // the byte-offset bits below bit 2 fall out of the shift and are ignored.
  assign addr_hi = rom_addr_i >> (DEPTH_LOG2 + 2);
  assign rd_idx  = rom_addr_i[DEPTH_LOG2+1:2];
  assign rom_data_o = (rom_ce_i && (addr_hi == 32'd0)) ? mem[rd_idx] : 32'd0;

  // State register plus the registered core reset, which tracks next_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      core_rst_o <= 1'b1;
    end else begin
      state      <= next_state;
      core_rst_o <= (next_state != RUN);
    end
  end

  // Next-state decode for the loader protocol.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (ld_start_i) next_state = LEN_HI;
      LEN_HI: if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0)               next_state = RUN;
          else if ({1'b0, len_full} > CAP)     next_state = ERR;
          else                                 next_state = DATA;
        end
      end
      DATA: begin
        if (word_done && ({{(16-DEPTH_LOG2-1){1'b0}}, count_inc} == len))
          next_state = RUN;
      end
      RUN:     if (ld_start_i) next_state = LEN_HI;
      ERR:     if (ld_start_i) next_state = LEN_HI;
      default: next_state = IDLE;
    endcase
  end

  // Loader-facing outputs decoded from the current state.
  always_comb begin
    ld_ready_o = 1'b0;
    ld_err_o   = 1'b0;
    unique case (state)
      LEN_HI, LEN_LO, DATA: ld_ready_o = 1'b1;
      ERR:                  ld_err_o   = 1'b1;
      default: ;
    endcase
  end

  // Length capture, byte assembly and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= 8'd0;
      len      <= 16'd0;
      word_sr  <= 24'd0;
      byte_idx <= 2'd0;
      count    <= '0;
    end else if (accept) begin
      unique case (state)
        LEN_HI: len_hi <= ld_byte_i;
        LEN_LO: begin
          len      <= len_full;
          byte_idx <= 2'd0;
          count    <= '0;
        end
        DATA: begin
          word_sr  <= {word_sr[15:0], ld_byte_i};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) count <= count_inc;
        end
        default: ;
      endcase
    end
  end

  // Word write on the fourth byte; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (word_done && !rst)
      mem[count[DEPTH_LOG2-1:0]] <= {word_sr, ld_byte_i};
  end

  assign ld_count_o = count;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader with DEPTH_LOG2 = 10.
module tb_inst_rom_loader;

  localparam int DL2 = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            rom_ce_i;
  logic [31:0]     rom_addr_i;
  logic [31:0]     rom_data_o;
  logic            ld_start_i;
  logic            ld_valid_i;
  logic [7:0]      ld_byte_i;
  logic            ld_ready_o;
  logic [DL2:0]    ld_count_o;
  logic            ld_err_o;
  logic            core_rst_o;

  int checks = 0;
  int errors = 0;

  inst_rom_loader #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
    .ld_ready_o(ld_ready_o), .ld_count_o(ld_count_o), .ld_err_o(ld_err_o),
    .core_rst_o(core_rst_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_check(input string name, input logic ce, input logic [31:0] addr,
                             input logic [31:0] exp);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    #1;
    check(name, rom_data_o, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    ld_valid_i = 1'b1;
    ld_byte_i  = b;
    step();
    ld_valid_i = 1'b0;
    ld_byte_i  = 8'hxx;
    if (gap) step();
  endtask

  task automatic pulse_start();
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
  endtask

  // Two-word program: length 2, words 0x34011100 and 0x34220020.
  task automatic load_two(input bit gap, input string tag);
    logic [7:0] bs [10];
    bs = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h22, 8'h00, 8'h20};
    pulse_start();
    check({tag, "_ready_lenhi"}, 32'(ld_ready_o), 32'd1);
    for (int i = 0; i < 9; i++) send_byte(bs[i], gap);
    check({tag, "_corerst_before_last"}, 32'(core_rst_o), 32'd1);
    send_byte(bs[9], 1'b0);
    check({tag, "_corerst_after_last"}, 32'(core_rst_o), 32'd0);
    check({tag, "_count"}, 32'(ld_count_o), 32'd2);
    check({tag, "_ready_run"}, 32'(ld_ready_o), 32'd0);
  endtask

  fetch_vec_t fv [7];

  initial begin
    fv[0] = '{1'b1, 32'h0000_0000, 32'h3401_1100};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h3422_0020};
    fv[2] = '{1'b1, 32'h0000_0006, 32'h3422_0020};
    fv[3] = '{1'b1, 32'h0000_0003, 32'h3401_1100};
    fv[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[5] = '{1'b1, 32'h0001_0000, 32'h0000_0000};
    fv[6] = '{1'b1, 32'h8000_0004, 32'h0000_0000};

    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'd0;
    ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_byte_i = 8'h00;

    // Reset state
    step(); step();
    check("rst_core_rst", 32'(core_rst_o), 32'd1);
    check("rst_ready", 32'(ld_ready_o), 32'd0);
    check("rst_count", 32'(ld_count_o), 32'd0);
    check("rst_err", 32'(ld_err_o), 32'd0);
    rst = 1'b0;
    step();
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("idle_ready", 32'(ld_ready_o), 32'd0);
    check("idle_count", 32'(ld_count_o), 32'd0);
    check("idle_core_rst", 32'(core_rst_o), 32'd1);

    // Two-word load, then table of fetches
    load_two(1'b0, "load");
    for (int i = 0; i < 7; i++)
      fetch_check($sformatf("fetch_tbl%0d", i), fv[i].ce, fv[i].addr, fv[i].exp);

    // Reload from RUN with one word
    pulse_start();
    check("reload_core_rst", 32'(core_rst_o), 32'd1);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0);
    check("reload_core_rst_mid", 32'(core_rst_o), 32'd1);
    send_byte(8'hEF, 1'b0);
    check("reload_core_rel", 32'(core_rst_o), 32'd0);
    check("reload_count", 32'(ld_count_o), 32'd1);
    fetch_check("reload_w0", 1'b1, 32'h0, 32'hDEAD_BEEF);
    fetch_check("reload_w1", 1'b1, 32'h4, 32'h3422_0020);

    // Gapped load restores the original program
    load_two(1'b1, "gap");
    fetch_check("gap_w0", 1'b1, 32'h0, 32'h3401_1100);
    fetch_check("gap_w1", 1'b1, 32'h4, 32'h3422_0020);

    // Zero length goes straight to RUN
    pulse_start();
    send_byte(8'h00, 1'b0);
    check("len0_core_rst_lo", 32'(core_rst_o), 32'd1);
    send_byte(8'h00, 1'b0);
    check("len0_core_rst", 32'(core_rst_o), 32'd0);
    check("len0_count", 32'(ld_count_o), 32'd0);
    check("len0_ready", 32'(ld_ready_o), 32'd0);

    // Put a distinct word 0 in place before the reset-mid-load test
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
    fetch_check("pre_w0", 1'b1, 32'h0, 32'hDEAD_BEEF);

    // Over-capacity length aborts
    pulse_start();
    send_byte(8'h04, 1'b0); send_byte(8'h01, 1'b0);
    check("err_flag", 32'(ld_err_o), 32'd1);
    check("err_core_rst", 32'(core_rst_o), 32'd1);
    check("err_ready", 32'(ld_ready_o), 32'd0);
    send_byte(8'h12, 1'b0);
    step();
    check("err_hold", 32'(ld_err_o), 32'd1);
    pulse_start();
    check("err_cleared", 32'(ld_err_o), 32'd0);
    check("err_exit_ready", 32'(ld_ready_o), 32'd1);

    // Reset after 6 of 10 bytes of the two-word load
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", 32'(ld_ready_o), 32'd0);
    check("midrst_core_rst", 32'(core_rst_o), 32'd1);
    check("midrst_count", 32'(ld_count_o), 32'd0);
    fetch_check("midrst_w0", 1'b1, 32'h0, 32'h3401_1100);
    send_byte(8'h34, 1'b0);
    check("midrst_idle_ready", 32'(ld_ready_o), 32'd0);

    // Fresh load after reset, with ld_start held mid-stream (ignored)
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    ld_start_i = 1'b1;
    send_byte(8'hCC, 1'b0);
    ld_start_i = 1'b0;
    send_byte(8'hDD, 1'b0);
    check("fresh_count_mid", 32'(ld_count_o), 32'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    check("fresh_core_rst_mid", 32'(core_rst_o), 32'd1);
    send_byte(8'h04, 1'b0);
    check("fresh_core_rst", 32'(core_rst_o), 32'd0);
    check("fresh_count", 32'(ld_count_o), 32'd2);
    fetch_check("fresh_w0", 1'b1, 32'h0, 32'hAABB_CCDD);
    fetch_check("fresh_w1", 1'b1, 32'h4, 32'h0102_0304);
    fetch_check("fresh_ce0", 1'b0, 32'h4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
